apb_master_32: RTL
==================

Name: apb_master_32

Overview:
- APB4 requester that converts a simple valid/ready command interface into single APB transfers.
- Sits directly upstream of the team's APB slave blocks and drives their psel/penable/paddr/pwrite/pwdata/pprot/pstrb inputs.
- Returns the read data, or the error status, through a valid/ready response channel.
- One transfer is in flight at a time. All APB outputs are registered.

Parameters:
- TIMEOUT_CYC, 256, number of ACCESS-phase cycles without pready before the transfer is aborted (used only with APB_TIMEOUT_EN); legal range 2..65535.

Ports:
- i_pclk  input  1  clock
- i_presetn  input  1  reset, asynchronous, active-low
- i_req_valid  input  1  command valid
- o_req_ready  output  1  command accepted when high together with i_req_valid
- i_req_write  input  1  1 = write, 0 = read
- i_req_addr  input  32  byte address
- i_req_wdata  input  32  write data
- i_req_strb  input  4  write byte strobes
- i_req_prot  input  3  protection attributes
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response consumed
- o_rsp_rdata  output  32  read data (0 for writes)
- o_rsp_err  output  1  pslverr, or timeout abort
- o_psel  output  1  APB select
- o_penable  output  1  APB enable
- o_paddr  output  32  APB address
- o_pwrite  output  1  APB direction
- o_pwdata  output  32  APB write data
- o_pprot  output  3  APB protection
- o_pstrb  output  4  APB strobes
- i_prdata  input  32  APB read data
- i_pready  input  1  APB ready
- i_pslverr  input  1  APB slave error

Behaviour:
- Clock and reset: single clock i_pclk. Reset i_presetn is asynchronous, active-low.
- Reset values:
  - FSM goes to IDLE.
  - o_psel, o_penable, o_pwrite, o_rsp_valid and o_rsp_err are 0.
  - o_paddr, o_pwdata, o_rsp_rdata, o_pprot and o_pstrb are 0.
  - o_req_ready is 1 after reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_req_ready = 1, decoded directly from state.
  - On i_req_valid, latch the command into the o_p* registers and go to SETUP.
  - Next cycle: o_psel = 1, o_penable = 0.
  - o_pstrb = i_req_strb for writes and 4'b0000 for reads.
  - o_pwdata = i_req_wdata for writes and 0 for reads.
- SETUP: lasts exactly one cycle, then ACCESS with o_penable = 1.
- ACCESS:
  - Hold paddr, pwrite, pwdata, pprot and pstrb stable.
  - On i_pready = 1:
    - o_rsp_rdata <= (read ? i_prdata : 0).
    - o_rsp_err <= i_pslverr.
    - Next cycle: o_psel = o_penable = 0 and the FSM is in RESP.
  - i_prdata and i_pslverr are ignored in every cycle except the ACCESS cycle with i_pready = 1.
- RESP:
  - o_rsp_valid = 1. Response data and error are held until i_rsp_ready = 1, then IDLE.
  - The response handshake cycle clears o_rsp_valid on the next edge.
- Latency and throughput:
  - A transfer with zero wait states gives accept at cycle 0, SETUP at 1, ACCESS at 2, and o_rsp_valid at 3.
  - Minimum spacing between accepted commands is 4 cycles.
  - Each wait state adds one cycle.
- Back-pressure:
  - o_req_ready = 0 in SETUP, ACCESS and RESP.
  - Commands presented then are not accepted and must be held by the requester.
- i_pready in SETUP is ignored.
- Asynchronous reset mid-transfer:
  - o_psel and o_penable drop immediately.
  - Any pending response is discarded.
  - No response is issued for the aborted command.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to ACCESS and increments every ACCESS cycle with i_pready = 0.
  - When the count reaches TIMEOUT_CYC - 1 with pready still low, the transfer is aborted.
  - On abort: o_psel and o_penable drop next cycle, RESP is entered with o_rsp_err = 1 and o_rsp_rdata = 32'h0.
  - If i_pready = 1 arrives in the same cycle the timeout fires, pready wins and a normal completion is reported.
- Without the macro: no counter exists and ACCESS waits indefinitely for i_pready.

Test Plan:
- Write with zero wait states: req addr=0x0000_0010, wdata=0xA5A5_1234, strb=0xF, prot=3'b010 ->
  - SETUP on cycle 1 (psel=1, penable=0) with paddr/pwdata/pstrb/pprot matching the request.
  - ACCESS on cycle 2.
  - o_rsp_valid on cycle 3 with err=0 and rdata=0.
- Read with 3 wait states: addr=0x0000_0004, i_prdata=0xCAFE_F00D at pready ->
  - o_pstrb=0.
  - Signals stable for 4 ACCESS cycles.
  - rsp_rdata=0xCAFE_F00D, err=0.
- Slave error: read with pslverr=1 at pready -> rsp_err=1, and the next command is accepted normally afterwards.
- Response back-pressure: i_rsp_ready held 0 for 5 cycles while i_req_valid=1 ->
  - rsp_valid and rsp_rdata stay stable.
  - o_req_ready stays 0.
  - The new command is accepted only in IDLE after the handshake.
- Reset mid-ACCESS: assert i_presetn=0 during wait states -> psel and penable are 0 immediately, no rsp_valid after release, and o_req_ready=1.
- APB_TIMEOUT_EN, TIMEOUT_CYC=8, pready stuck at 0 -> abort after 8 ACCESS cycles with rsp_err=1 and rdata=0. A pready that coincides with the 8th cycle completes normally with err=i_pslverr.

Source files
------------

// File: rtl/apb_master_32.sv
// APB4 requester: turns a valid/ready command into one APB transfer and returns a valid/ready response.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a command; o_req_ready high
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high, waiting for pready
// RESP   | response held on o_rsp_* until i_rsp_ready
module apb_master_32 #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        i_pclk,
  input  logic        i_presetn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_strb,
  input  logic [2:0]  i_req_prot,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_psel,
  output logic        o_penable,
  output logic [31:0] o_paddr,
  output logic        o_pwrite,
  output logic [31:0] o_pwdata,
  output logic [2:0]  o_pprot,
  output logic [3:0]  o_pstrb,
  input  logic [31:0] i_prdata,
  input  logic        i_pready,
  input  logic        i_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e      state_q;
  logic        psel_q, penable_q, pwrite_q;
  logic [31:0] paddr_q, pwdata_q;
  logic [2:0]  pprot_q;
  logic [3:0]  pstrb_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wait_cnt_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= i_req_addr;
            pwrite_q  <= i_req_write;
            pprot_q   <= i_req_prot;
            pwdata_q  <= i_req_write ? i_req_wdata : 32'h0;
            pstrb_q   <= i_req_write ? i_req_strb : 4'b0000;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          // pready has priority over a timeout firing in the same cycle
          if (i_pready) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= i_pslverr;
            rsp_rdata_q <= pwrite_q ? 32'h0 : i_prdata;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt_q == TO_LAST) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'h0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        RESP: begin
          if (i_rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_psel      = psel_q;
  assign o_penable   = penable_q;
  assign o_paddr     = paddr_q;
  assign o_pwrite    = pwrite_q;
  assign o_pwdata    = pwdata_q;
  assign o_pprot     = pprot_q;
  assign o_pstrb     = pstrb_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rsp_rdata_q;

endmodule
